seg7_scan_driver: RTL and testbench

//  Time-multiplexed hex driver for an N-digit common-anode 7-segment display; successor to the single-digit BCD display path.

---
 rtl/seg7_scan_driver_pkg.sv | 36 +++
 rtl/seg7_hex_decode.sv | 36 +++
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Active-low segment patterns (bit 0 = a .. bit 6 = g, bit 7 = dp) and
// the cathode bit indices. Leading-zero blanking is enabled by defining
// SEG7_LEADING_ZERO_BLANK_EN at build time.
package seg7_scan_driver_pkg;

  // Active-low cathode patterns with the decimal point dark.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Cathode bit positions.
  localparam int CATH_A  = 0;
  localparam int CATH_G  = 6;
  localparam int CATH_DP = 7;

  // Scan index width; a single-digit display still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point -> active-low cathode pattern.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  // Glyph lookup, then overlay the active-low decimal point.
  always_comb begin
    w_pat = SEG_BLANK;
    case (i_nib)
      4'h0: w_pat = SEG_0;
      4'h1: w_pat = SEG_1;
      4'h2: w_pat = SEG_2;
      4'h3: w_pat = SEG_3;
      4'h4: w_pat = SEG_4;
      4'h5: w_pat = SEG_5;
      4'h6: w_pat = SEG_6;
      4'h7: w_pat = SEG_7;
      4'h8: w_pat = SEG_8;
      4'h9: w_pat = SEG_9;
      4'hA: w_pat = SEG_A;
      4'hB: w_pat = SEG_B;
      4'hC: w_pat = SEG_C;
      4'hD: w_pat = SEG_D;
      4'hE: w_pat = SEG_E;
      default: w_pat = SEG_F;
    endcase
    o_seg = {~i_dp, w_pat[CATH_G:CATH_A]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex driver for a common-anode 7-segment display.
// A prescaler divides each digit slot into REFRESH_DIV cycles; the first
// GUARD_CYC cycles of every slot keep all anodes off to stop ghosting.
// Inputs are snapshotted once per frame so a digit never tears mid-scan.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  // Scan state
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_first;

  // Frame snapshot
  logic [NUM_DIGITS-1:0][3:0] r_snap_dig;
  logic [NUM_DIGITS-1:0]      r_snap_dp;
  logic [NUM_DIGITS-1:0]      r_snap_en;

  // Output registers
  logic [NUM_DIGITS-1:0] r_anode;
  logic [7:0]            r_cathode;
  logic                  r_frame_start;

  logic                  w_wrap;
  logic                  w_last;
  logic                  w_load;
  logic                  w_guard;
  logic                  w_show;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic [7:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_sel;

  assign w_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
  // r_first makes the release edge load a fresh snapshot, so the first
  // frame after reset starts with current inputs rather than zeros.
  assign w_load  = r_first | (w_wrap & w_last);
  assign w_guard = (r_cnt < CNT_W'(GUARD_CYC));
  assign w_nib   = r_snap_dig[r_idx];
  assign w_dp    = r_snap_dp[r_idx];
  assign w_sel   = ~(NUM_DIGITS'(1) << r_idx);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_blank_nxt;
  logic [NUM_DIGITS-1:0] r_blank;

  // Leading-zero mask from the live inputs, walking down from the top
  // digit; disabled digits do not break a run of leading zeros.
  always_comb begin : lz_mask
    logic zero_above;
    logic zero_here;
    zero_above  = 1'b1;
    zero_here   = 1'b0;
    w_blank_nxt = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_here      = (digits[4*i +: 4] == 4'h0) && !dp_mask[i];
      w_blank_nxt[i] = (i != 0) && zero_here && zero_above;
      zero_above     = zero_above && (!digit_en[i] || zero_here);
    end
  end

  // Blank mask is captured alongside the snapshot it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_blank <= '0;
    else if (w_load) r_blank <= w_blank_nxt;
  end

  assign w_show = r_snap_en[r_idx] & ~r_blank[r_idx];
`else
  assign w_show = r_snap_en[r_idx];
`endif

  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .i_dp  (w_dp),
    .o_seg (w_seg)
  );

  // Prescaler and scan index; held at slot 0 cycle 0 through the release edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (!r_first) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Frame snapshot; frame_start marks the first cycle the new values are live.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap_dig    <= '0;
      r_snap_dp     <= '0;
      r_snap_en     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      if (w_load) begin
        r_snap_dig <= digits;
        r_snap_dp  <= dp_mask;
        r_snap_en  <= digit_en;
      end
    end
  end

  // Registered pin drivers: dark during guard or for disabled/blanked digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else if (w_guard || !w_show) begin
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= w_sel;
      r_cathode <= w_seg;
    end
  end

  assign anode       = r_anode;
  assign cathode     = r_cathode;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle guard).
// A reference model turns each clock edge into the expected pin state for
// the following cycle and queues it; a monitor compares every cycle.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int F  = N * RD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]   dp_mask = '0;
  logic [N-1:0]   digit_en = '0;
  logic [7:0]     cathode;
  logic [N-1:0]   anode;
  logic           frame_start;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYC(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .cathode     (cathode),
    .anode       (anode),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [7:0]   ca;
    logic         fs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: p = cycles since the release edge; frame snapshot arrays.
  int p = 0;
  bit in_rst = 1'b1;
  int m_dig [N];
  bit m_dp  [N];
  bit m_en  [N];
  bit m_blk [N];

  function automatic bit lz_blank(input int i);
    bit b;
    b = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0 && m_dig[i] == 0 && !m_dp[i]) begin
      b = 1'b1;
      for (int j = i + 1; j < N; j++)
        if (m_en[j] && (m_dig[j] != 0 || m_dp[j])) b = 1'b0;
    end
`endif
    return b;
  endfunction

  // Reference model: one expected pin state per clock edge.
  initial forever begin
    exp_t e;
    int q, slot, pos;
    @(posedge clk);
    e.an = '1;
    e.ca = 8'hFF;
    e.fs = 1'b0;
    if (!rst_n) begin
      in_rst = 1'b1;
    end else begin
      if (in_rst) p = 0;
      else        p++;
      in_rst = 1'b0;
      e.fs = (p % F == 0);
      if (p > 0) begin
        q    = p - 1;
        slot = (q / RD) % N;
        pos  = q % RD;
        if (pos >= G && m_en[slot] && !m_blk[slot]) begin
          e.an = ~(N'(1) << slot);
          e.ca = seg_tab[m_dig[slot]] & (m_dp[slot] ? 8'h7F : 8'hFF);
        end
      end
      if (p % F == 0) begin
        for (int i = 0; i < N; i++) begin
          m_dig[i] = int'(digits[4*i +: 4]);
          m_dp[i]  = dp_mask[i];
          m_en[i]  = digit_en[i];
        end
        for (int i = 0; i < N; i++) m_blk[i] = lz_blank(i);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare the pins mid-cycle against the queued expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (anode !== e.an || cathode !== e.ca || frame_start !== e.fs) begin
        bad++;
        $display("FAIL pins t=%0t p=%0d anode got %h exp %h cathode got %h exp %h frame_start got %b exp %b",
                 $time, p, anode, e.an, cathode, e.ca, frame_start, e.fs);
      end
    end
  end

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic set_in(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] en);
    digits   = d;
    dp_mask  = dp;
    digit_en = en;
  endtask

  task automatic wait_slot(input int s);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2 * F && !hit; k++) begin
      @(negedge clk);
      if (!in_rst && ((p % F) / RD) == s) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_slot got no slot %0d within %0d cycles", s, 2 * F);
    end
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    cycles(n);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held for 5 cycles: pins dark, no frame_start.
    set_in(16'h4321, 4'h0, 4'hF);
    cycles(5);
    rst_n = 1'b1;

    // Plain scan of 4321.
    cycles(2 * F + 3);

    // Mid-frame input change is deferred to the next frame.
    wait_slot(1);
    set_in(16'h8765, 4'h0, 4'hF);
    cycles(2 * F);

    // Enables and decimal point.
    set_in(16'h000F, 4'h1, 4'b0101);
    cycles(2 * F + 5);

    // One-cycle reset during slot 2.
    wait_slot(2);
    pulse_reset(1);
    cycles(F + 4);

    // Leading-zero pattern.
    set_in(16'h0070, 4'h0, 4'hF);
    cycles(2 * F);

    // Change exactly before a snapshot edge: captured in the new frame.
    wait_slot(N - 1);
    cycles(RD - 1 - ((p % F) % RD));
    set_in(16'hA0B9, 4'h6, 4'hE);
    cycles(F + 2);

    // Randomized input changes and occasional resets.
    for (int r = 0; r < 50; r++) begin
      cycles($urandom_range(1, 40));
      set_in(16'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) pulse_reset($urandom_range(1, 3));
    end
    cycles(F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
